// File: rtl/ahblite_slave_mux.sv
// ahblite_slave_mux
// AHB-Lite response multiplexer and default slave for the Cortex-M0 bus matrix.
// The decoder's select lines are captured at the end of each address phase and
// held for the data phase. The captured select steers the chosen slave's
// HREADYOUT/HRESP/HRDATA back to the master. Unmapped active transfers, and
// transfers to disabled ports, get the two-cycle ERROR response from a built-in
// default slave.
//
// Handshake: an address phase completes, and its selects and HTRANS are
// captured, on a rising HCLK edge where HREADY (this block's output) is 1. While
// HREADY is 0, the pending address-phase inputs are ignored. The data-phase
// outputs come only from registered state and the slave inputs. No
// combinational path runs from any Pn_HSEL or HTRANS to the outputs.

module ahblite_slave_mux #(
    parameter bit PORT0_EN = 1'b1,
    parameter bit PORT1_EN = 1'b1,
    parameter bit PORT2_EN = 1'b1,
    parameter bit PORT3_EN = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [1:0]  HTRANS,
    input  logic        P0_HSEL,
    input  logic        P1_HSEL,
    input  logic        P2_HSEL,
    input  logic        P3_HSEL,
    input  logic        P0_HREADYOUT,
    input  logic        P1_HREADYOUT,
    input  logic        P2_HREADYOUT,
    input  logic        P3_HREADYOUT,
    input  logic        P0_HRESP,
    input  logic        P1_HRESP,
    input  logic        P2_HRESP,
    input  logic        P3_HRESP,
    input  logic [31:0] P0_HRDATA,
    input  logic [31:0] P1_HRDATA,
    input  logic [31:0] P2_HRDATA,
    input  logic [31:0] P3_HRDATA,
    output logic        HREADY,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic [1:0]  dbg_state,
    output logic [2:0]  dbg_sel
);

    // Default-slave FSM states.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ERR1 = 2'd1;
    localparam logic [1:0] ST_ERR2 = 2'd2;

    // Data-phase select encodings. SEL_NONE covers both "nothing active" and
    // "default slave". The FSM state tells those two cases apart.
    localparam logic [2:0] SEL_NONE = 3'd0;
    localparam logic [2:0] SEL_P0   = 3'd1;
    localparam logic [2:0] SEL_P1   = 3'd2;
    localparam logic [2:0] SEL_P2   = 3'd3;
    localparam logic [2:0] SEL_P3   = 3'd4;

    logic [3:0] sel_mask;
    logic [2:0] sel_d;
    logic [2:0] sel_q;
    logic [1:0] state_d;
    logic [1:0] state_q;
    logic       capture;
    logic       unmapped_active;
    logic       unused_htrans0;

    // Only HTRANS[1] distinguishes an active transfer from IDLE/BUSY.
    assign unused_htrans0 = HTRANS[0];

    // A disabled port's select is forced low, so its accesses fall to the default slave.
    assign sel_mask = {P3_HSEL & PORT3_EN,
                       P2_HSEL & PORT2_EN,
                       P1_HSEL & PORT1_EN,
                       P0_HSEL & PORT0_EN};

    // An address phase ends whenever the bus reports ready.
    assign capture = HREADY;

    // Choose the next data-phase select, giving the lowest-numbered port priority.
    always_comb begin
        sel_d = SEL_NONE;
        if (sel_mask[0]) begin
            sel_d = SEL_P0;
        end else if (sel_mask[1]) begin
            sel_d = SEL_P1;
        end else if (sel_mask[2]) begin
            sel_d = SEL_P2;
        end else if (sel_mask[3]) begin
            sel_d = SEL_P3;
        end
    end

    // An active transfer that no enabled port claims must be answered with ERROR.
    assign unmapped_active = (sel_d == SEL_NONE) && HTRANS[1];

    // Hold the captured select for the data phase, and freeze it during wait states.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            sel_q <= SEL_NONE;
        end else if (capture) begin
            sel_q <= sel_d;
        end
    end

    // Compute the next default-slave state. ERR2 can chain straight into ERR1
    // when a new unmapped active transfer is captured (back-to-back errors).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (capture && unmapped_active) begin
                    state_d = ST_ERR1;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            ST_ERR2: begin
                if (capture && unmapped_active) begin
                    state_d = ST_ERR1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register the default-slave state.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Drive the data-phase response. A default-slave ERROR takes precedence
    // over routing. With no port selected, the response is a zero-wait OKAY.
    always_comb begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = 32'h0;
        case (state_q)
            ST_ERR1: begin
                HREADY = 1'b0;
                HRESP  = 1'b1;
            end
            ST_ERR2: begin
                HREADY = 1'b1;
                HRESP  = 1'b1;
            end
            default: begin
                case (sel_q)
                    SEL_P0: begin
                        HREADY = P0_HREADYOUT;
                        HRESP  = P0_HRESP;
                        HRDATA = P0_HRDATA;
                    end
                    SEL_P1: begin
                        HREADY = P1_HREADYOUT;
                        HRESP  = P1_HRESP;
                        HRDATA = P1_HRDATA;
                    end
                    SEL_P2: begin
                        HREADY = P2_HREADYOUT;
                        HRESP  = P2_HRESP;
                        HRDATA = P2_HRDATA;
                    end
                    SEL_P3: begin
                        HREADY = P3_HREADYOUT;
                        HRESP  = P3_HRESP;
                        HRDATA = P3_HRDATA;
                    end
                    default: begin
                        HREADY = 1'b1;
                        HRESP  = 1'b0;
                        HRDATA = 32'h0;
                    end
                endcase
            end
        endcase
    end

    // Expose the internal state for observation.
    assign dbg_state = state_q;
    assign dbg_sel   = sel_q;

endmodule

// File: tb/tb_ahblite_slave_mux.sv
// tb_ahblite_slave_mux
// Two instances share one set of inputs: dut_a has every port enabled, and
// dut_b has port 3 disabled. A transaction-level model tracks, for each
// instance, which port owns the current data phase and how many default-slave
// error cycles are still owed. The model derives the expected outputs from
// those two values.

module tb_ahblite_slave_mux;

    logic        clk;
    logic        rst;
    logic [1:0]  htrans;
    logic        hsel [4];
    logic        hro  [4];
    logic        hrs  [4];
    logic [31:0] hrd  [4];

    logic        hready_o [2];
    logic        hresp_o  [2];
    logic [31:0] hrdata_o [2];
    logic [1:0]  dbg_state_o [2];
    logic [2:0]  dbg_sel_o   [2];

    int n_checks = 0;
    int n_errors = 0;

    // Per-instance model: owning port (-1 = none) and error cycles still owed.
    int       m_port [2];
    int       m_err  [2];
    bit [3:0] en_mask [2];

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    ahblite_slave_mux dut_a (
        .HCLK(clk), .HRESET(rst), .HTRANS(htrans),
        .P0_HSEL(hsel[0]), .P1_HSEL(hsel[1]), .P2_HSEL(hsel[2]), .P3_HSEL(hsel[3]),
        .P0_HREADYOUT(hro[0]), .P1_HREADYOUT(hro[1]), .P2_HREADYOUT(hro[2]), .P3_HREADYOUT(hro[3]),
        .P0_HRESP(hrs[0]), .P1_HRESP(hrs[1]), .P2_HRESP(hrs[2]), .P3_HRESP(hrs[3]),
        .P0_HRDATA(hrd[0]), .P1_HRDATA(hrd[1]), .P2_HRDATA(hrd[2]), .P3_HRDATA(hrd[3]),
        .HREADY(hready_o[0]), .HRESP(hresp_o[0]), .HRDATA(hrdata_o[0]),
        .dbg_state(dbg_state_o[0]), .dbg_sel(dbg_sel_o[0])
    );

    ahblite_slave_mux #(.PORT3_EN(1'b0)) dut_b (
        .HCLK(clk), .HRESET(rst), .HTRANS(htrans),
        .P0_HSEL(hsel[0]), .P1_HSEL(hsel[1]), .P2_HSEL(hsel[2]), .P3_HSEL(hsel[3]),
        .P0_HREADYOUT(hro[0]), .P1_HREADYOUT(hro[1]), .P2_HREADYOUT(hro[2]), .P3_HREADYOUT(hro[3]),
        .P0_HRESP(hrs[0]), .P1_HRESP(hrs[1]), .P2_HRESP(hrs[2]), .P3_HRESP(hrs[3]),
        .P0_HRDATA(hrd[0]), .P1_HRDATA(hrd[1]), .P2_HRDATA(hrd[2]), .P3_HRDATA(hrd[3]),
        .HREADY(hready_o[1]), .HRESP(hresp_o[1]), .HRDATA(hrdata_o[1]),
        .dbg_state(dbg_state_o[1]), .dbg_sel(dbg_sel_o[1])
    );

    // ---------------- model ----------------
    function automatic void model_out(input int k, output logic r, output logic rs,
                                      output logic [31:0] d);
        if (m_err[k] == 2) begin
            r = 1'b0; rs = 1'b1; d = 32'h0;
        end else if (m_err[k] == 1) begin
            r = 1'b1; rs = 1'b1; d = 32'h0;
        end else if (m_port[k] >= 0) begin
            r = hro[m_port[k]]; rs = hrs[m_port[k]]; d = hrd[m_port[k]];
        end else begin
            r = 1'b1; rs = 1'b0; d = 32'h0;
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_port[k] = -1;
                m_err[k]  = 0;
            end else begin
                logic r, rs;
                logic [31:0] d;
                int lowest;
                model_out(k, r, rs, d);
                if (r) begin
                    lowest = -1;
                    for (int j = 3; j >= 0; j--) begin
                        if (hsel[j] && en_mask[k][j]) lowest = j;
                    end
                    m_port[k] = lowest;
                    m_err[k]  = (lowest < 0 && htrans[1]) ? 2 : 0;
                end else if (m_err[k] > 0) begin
                    m_err[k] = m_err[k] - 1;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 30)
                $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic check_lit(input string nm, input int k, input logic r, input logic rs,
                             input logic [31:0] d);
        chk($sformatf("%s_hready%0d", nm, k), {31'h0, hready_o[k]}, {31'h0, r});
        chk($sformatf("%s_hresp%0d", nm, k), {31'h0, hresp_o[k]}, {31'h0, rs});
        chk($sformatf("%s_hrdata%0d", nm, k), hrdata_o[k], d);
    endtask

    // Compare both instances against the model on every cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic r, rs;
            logic [31:0] d;
            model_out(k, r, rs, d);
            chk($sformatf("model_hready%0d", k), {31'h0, hready_o[k]}, {31'h0, r});
            chk($sformatf("model_hresp%0d", k), {31'h0, hresp_o[k]}, {31'h0, rs});
            chk($sformatf("model_hrdata%0d", k), hrdata_o[k], d);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        htrans = 2'b00;
        for (int j = 0; j < 4; j++) begin
            hsel[j] = 1'b0;
            hro[j]  = 1'b1;
            hrs[j]  = 1'b0;
            hrd[j]  = 32'h1000_0000 + j;
        end
    endtask

    task automatic random_inputs();
        htrans = 2'($urandom_range(0, 3));
        for (int j = 0; j < 4; j++) begin
            hsel[j] = ($urandom_range(0, 9) < 3);
            hro[j]  = ($urandom_range(0, 3) != 0);
            hrs[j]  = ($urandom_range(0, 9) == 0);
            hrd[j]  = $urandom;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        en_mask[0] = 4'b1111;
        en_mask[1] = 4'b0111;
        m_port[0] = -1; m_port[1] = -1;
        m_err[0] = 0;   m_err[1] = 0;

        // Reset with arbitrary inputs.
        rst = 1'b1;
        random_inputs();
        #3;
        check_lit("reset", 0, 1'b1, 1'b0, 32'h0);
        check_lit("reset", 1, 1'b1, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        clear_inputs();
        rst = 1'b0;
        cyc();
        @(negedge clk);
        check_lit("post_reset", 0, 1'b1, 1'b0, 32'h0);

        // Read through P1.
        cyc();
        hsel[1] = 1'b1; htrans = 2'b10;
        cyc();
        hsel[1] = 1'b0; htrans = 2'b00;
        hrd[1] = 32'hDEAD_BEEF; hro[1] = 1'b1; hrs[1] = 1'b0;
        @(negedge clk);
        check_lit("p1_read", 0, 1'b1, 1'b0, 32'hDEAD_BEEF);

        // Wait states on P2 while P0 is pending in the address phase.
        cyc();
        hsel[2] = 1'b1; htrans = 2'b10;
        cyc();
        hsel[2] = 1'b0; hsel[0] = 1'b1;
        hro[2] = 1'b0; hrd[2] = 32'h2222_3333; hrd[0] = 32'h0A0A_5555;
        @(negedge clk);
        check_lit("p2_wait1", 0, 1'b0, 1'b0, 32'h2222_3333);
        cyc();
        @(negedge clk);
        check_lit("p2_wait2", 0, 1'b0, 1'b0, 32'h2222_3333);
        cyc();
        hro[2] = 1'b1;
        @(negedge clk);
        check_lit("p2_done", 0, 1'b1, 1'b0, 32'h2222_3333);
        cyc();
        hsel[0] = 1'b0; htrans = 2'b00;
        @(negedge clk);
        check_lit("p0_after_wait", 0, 1'b1, 1'b0, 32'h0A0A_5555);
        check_lit("p0_after_wait", 1, 1'b1, 1'b0, 32'h0A0A_5555);

        // Unmapped active transfer.
        cyc();
        htrans = 2'b10;
        cyc();
        htrans = 2'b00;
        @(negedge clk);
        check_lit("unmap_err1", 0, 1'b0, 1'b1, 32'h0);
        cyc();
        @(negedge clk);
        check_lit("unmap_err2", 0, 1'b1, 1'b1, 32'h0);
        cyc();
        @(negedge clk);
        check_lit("unmap_idle", 0, 1'b1, 1'b0, 32'h0);

        // Back-to-back errors: a new unmapped NONSEQ is captured in ERR2.
        htrans = 2'b10;
        cyc();
        @(negedge clk);
        check_lit("b2b_err1a", 0, 1'b0, 1'b1, 32'h0);
        cyc();
        @(negedge clk);
        check_lit("b2b_err2a", 0, 1'b1, 1'b1, 32'h0);
        cyc();
        htrans = 2'b00;
        @(negedge clk);
        check_lit("b2b_err1b", 0, 1'b0, 1'b1, 32'h0);
        cyc();
        @(negedge clk);
        check_lit("b2b_err2b", 0, 1'b1, 1'b1, 32'h0);
        cyc();
        @(negedge clk);
        check_lit("b2b_idle", 0, 1'b1, 1'b0, 32'h0);

        // Disabled port 3 on dut_b, enabled on dut_a.
        hsel[3] = 1'b1; htrans = 2'b10;
        cyc();
        hsel[3] = 1'b0; htrans = 2'b00;
        hro[3] = 1'b1; hrs[3] = 1'b0; hrd[3] = 32'h3333_CAFE;
        @(negedge clk);
        check_lit("p3_enabled", 0, 1'b1, 1'b0, 32'h3333_CAFE);
        check_lit("p3_disabled_err1", 1, 1'b0, 1'b1, 32'h0);
        cyc();
        @(negedge clk);
        check_lit("p3_disabled_err2", 1, 1'b1, 1'b1, 32'h0);

        // Unmapped IDLE transfer: zero-wait OKAY.
        cyc();
        @(negedge clk);
        check_lit("unmap_idle_okay", 0, 1'b1, 1'b0, 32'h0);
        check_lit("unmap_idle_okay", 1, 1'b1, 1'b0, 32'h0);

        // Reset in the middle of ERR1.
        htrans = 2'b10;
        cyc();
        htrans = 2'b00;
        #2;
        check_lit("pre_rst_err1", 0, 1'b0, 1'b1, 32'h0);
        rst = 1'b1;
        #1;
        check_lit("mid_err_rst", 0, 1'b1, 1'b0, 32'h0);
        check_lit("mid_err_rst", 1, 1'b1, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        hsel[0] = 1'b1; htrans = 2'b10;
        cyc();
        hsel[0] = 1'b0; htrans = 2'b00;
        hrd[0] = 32'h1357_2468; hro[0] = 1'b1; hrs[0] = 1'b0;
        @(negedge clk);
        check_lit("p0_after_rst", 0, 1'b1, 1'b0, 32'h1357_2468);

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            cyc();
            rst = ($urandom_range(0, 199) == 0);
            random_inputs();
        end
        cyc();
        rst = 1'b0;
        repeat (2) cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ahblite_slave_mux.md
# ahblite_slave_mux

AHB-Lite response multiplexer and default slave for the Cortex-M0 bus matrix. It is the return path paired with the address decoder. It captures the decoder's per-port select lines in the address phase and holds them for the data phase. During the data phase it routes the selected slave's HREADYOUT, HRESP and HRDATA back to the master. Transfers to unmapped or disabled regions get the AHB two-cycle ERROR response from a built-in default slave.

## Interface
- PORT0_EN, default 1: port 0 (RAMCODE) enable; when 0, P0_HSEL is ignored and accesses fall to the default slave.
- PORT1_EN, default 1: port 1 (RAMDATA) enable, same rule.
- PORT2_EN, default 1: port 2 (GPIO) enable, same rule.
- PORT3_EN, default 1: port 3 (UART) enable, same rule.
- HCLK  in  1  bus clock; the single clock domain.
- HRESET  in  1  asynchronous, active-high reset.
- HTRANS  in  2  master transfer type; bit1=1 means NONSEQ/SEQ (active transfer).
- P0_HSEL..P3_HSEL  in  1 each  decoder select lines, address phase.
- P0_HREADYOUT..P3_HREADYOUT  in  1 each  slave ready.
- P0_HRESP..P3_HRESP  in  1 each  slave response (0=OKAY, 1=ERROR).
- P0_HRDATA..P3_HRDATA  in  32 each  slave read data.
- HREADY  out  1  bus ready, fed to the master and to all slaves.
- HRESP  out  1  bus response to the master.
- HRDATA  out  32  bus read data to the master.

## Operation
- Address-phase capture happens only when HREADY (this block's output) is 1. The data-phase select register sel_q is loaded from the masked selects:
  - sel_n = Pn_HSEL & PORTn_EN.
  - Priority is lowest index first if more than one is set: P0 > P1 > P2 > P3.
  - If no sel_n is set, the default slave is selected.
  - Default-active is recorded only if HTRANS[1]=1.
  - If HREADY=0, sel_q holds its value.
- Data-phase routing (combinational from sel_q):
  - Port n selected: HREADY=Pn_HREADYOUT, HRESP=Pn_HRESP, HRDATA=Pn_HRDATA.
  - Default slave, or nothing active: HRDATA=32'h0.
- Default-slave FSM, states IDLE, ERR1, ERR2:
  - IDLE: HREADY=1, HRESP=0. Go to ERR1 when an unmapped capture occurs with HTRANS[1]=1.
  - ERR1: HREADY=0, HRESP=1. Always go to ERR2.
  - ERR2: HREADY=1, HRESP=1. Go to ERR1 if a new unmapped active capture occurs this cycle (back-to-back errors); otherwise go to IDLE.
  - Addresses presented in ERR2 are captured normally, because HREADY=1.
- Unmapped IDLE or BUSY transfers get a zero-wait OKAY: FSM stays in IDLE, HREADY=1, HRESP=0.
- Slave-driven ERROR responses are passed through unchanged. The slave owns its own two-cycle sequencing.

## Timing
- Reset values:
  - sel_q = none, FSM = IDLE.
  - HREADY=1, HRESP=0, HRDATA=32'h0.
  - These take effect asynchronously on HRESET assertion.
- Reset mid-transfer (including in ERR1 or ERR2) abandons the response. Outputs return to reset values immediately. Capture resumes on the first HCLK edge after deassertion.
- Latency: zero added cycles. The data-phase outputs are combinational from sel_q and the slave inputs; sel_q updates on the HCLK edge that ends the address phase.
- Wait states: while the selected slave drives HREADYOUT=0, HREADY=0. Pending address-phase HSEL/HTRANS values are not captured until the cycle in which HREADY=1.
- No combinational path from any Pn_HSEL or HTRANS to HREADY, HRESP or HRDATA.
- An unmapped active transfer costs exactly 2 data-phase cycles: ERR1, then ERR2.

## Test plan
- Reset: assert HRESET with arbitrary inputs -> HREADY=1, HRESP=0, HRDATA=32'h0. After deassert with no selects and HTRANS=IDLE, outputs are unchanged.
- Read through P1: P1_HSEL=1, HTRANS=2'b10, HREADY=1 at cycle N; at cycle N+1, P1_HRDATA=32'hDEADBEEF and P1_HREADYOUT=1 -> HRDATA=32'hDEADBEEF, HREADY=1, HRESP=0 at N+1.
- Wait states: P2 selected, P2_HREADYOUT=0 for 2 cycles while P0_HSEL=1 is presented -> HREADY=0 for 2 cycles. P0 is captured only on the cycle P2_HREADYOUT=1. The next data phase returns P0_HRDATA.
- Unmapped active transfer: no Pn_HSEL, HTRANS=2'b10 -> next cycle HREADY=0/HRESP=1, following cycle HREADY=1/HRESP=1, then HREADY=1/HRESP=0. A second unmapped NONSEQ captured in ERR2 -> immediately ERR1 again.
- Disabled port and idle: PORT3_EN=0, P3_HSEL=1, HTRANS=2'b10 -> two-cycle ERROR, with P3 inputs ignored. Unmapped HTRANS=2'b00 -> HREADY=1, HRESP=0 with no wait.
- Reset mid-error: assert HRESET during ERR1 -> same cycle HREADY=1, HRESP=0, HRDATA=0. After release, a P0 access completes normally.
